// File: rtl/cache_tag_fill_pkg.sv
// Shared definitions for the 4-way tag store: geometry defaults, LRU age
// vector type and the fill/flush controller state encoding.
package cache_tag_fill_pkg;

  localparam int unsigned TAG_W    = 24;
  localparam int unsigned SET_W    = 3;
  localparam int unsigned NUM_WAYS = 4;
  localparam int unsigned WAY_W    = 2;

  typedef logic [NUM_WAYS-1:0][WAY_W-1:0] ages_t;

  // Way i starts with age i, so way 3 is the initial eviction candidate.
  localparam ages_t AGE_INIT = {2'd3, 2'd2, 2'd1, 2'd0};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEL,
    ST_WR,
    ST_FLUSH
  } state_e;

endpackage

// File: rtl/cache_tag_fill_lru4.sv
// Age-based LRU update for one 4-way set: the used way becomes youngest and
// every younger way ages by one. Also reports the oldest (age 3) way.
module lru4_update
  import cache_tag_fill_pkg::*;
(
  input  ages_t            age_i,
  input  logic [WAY_W-1:0] way_i,
  output ages_t            age_o,
  output logic [WAY_W-1:0] oldest_o
);

  always_comb begin
    age_o    = age_i;
    oldest_o = '0;
    for (int unsigned i = 0; i < NUM_WAYS; i++) begin
      if (age_i[i] < age_i[way_i]) begin
        age_o[i] = age_i[i] + 2'd1;
      end
      if (age_i[i] == 2'd3) begin
        oldest_o = WAY_W'(i);
      end
    end
    age_o[way_i] = '0;
  end

endmodule

// File: rtl/cache_tag_fill.sv
// Write side of the 4-way set-associative tag store: tag/valid/LRU state,
// line fills with victim selection, hit-driven LRU touches and flush.
module cache_tag_fill #(
  parameter int unsigned TAG_W = cache_tag_fill_pkg::TAG_W,
  parameter int unsigned SET_W = cache_tag_fill_pkg::SET_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fill_valid,
  output logic             fill_ready,
  input  logic [SET_W-1:0] fill_set,
  input  logic [TAG_W-1:0] fill_tag,
  output logic             fill_done,
  output logic [1:0]       fill_way,
  output logic             evict_valid,
  output logic [TAG_W-1:0] evict_tag,
  input  logic             touch_valid,
  input  logic [SET_W-1:0] touch_set,
  input  logic [1:0]       touch_way,
  input  logic             flush_req,
  output logic             flush_busy,
  input  logic [SET_W-1:0] rd_set,
  output logic [TAG_W-1:0] rd_tag0,
  output logic [TAG_W-1:0] rd_tag1,
  output logic [TAG_W-1:0] rd_tag2,
  output logic [TAG_W-1:0] rd_tag3,
  output logic [3:0]       rd_valid
);
  import cache_tag_fill_pkg::*;

  localparam int unsigned NUM_SETS = 1 << SET_W;

  state_e state_q, state_d;
  logic [SET_W-1:0] set_q, set_d;
  logic [TAG_W-1:0] ftag_q, ftag_d;
  logic [WAY_W-1:0] victim_q, victim_d;
  logic [TAG_W-1:0] old_tag_q, old_tag_d;
  logic             old_valid_q, old_valid_d;
  logic             flush_pend_q, flush_pend_d;
  logic [SET_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [NUM_SETS-1:0][NUM_WAYS-1:0][TAG_W-1:0] tags_q, tags_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]            valid_q, valid_d;
  ages_t [NUM_SETS-1:0]                         age_q, age_d;

  ages_t            fill_age_new, touch_age_new;
  logic [WAY_W-1:0] fill_oldest, unused_touch_oldest;
  logic [WAY_W-1:0] sel_victim;
  logic             touch_en;

  lru4_update u_fill_lru (
    .age_i    (age_q[set_q]),
    .way_i    (victim_q),
    .age_o    (fill_age_new),
    .oldest_o (fill_oldest)
  );

  lru4_update u_touch_lru (
    .age_i    (age_q[touch_set]),
    .way_i    (touch_way),
    .age_o    (touch_age_new),
    .oldest_o (unused_touch_oldest)
  );

  // Lowest-index invalid way wins; scanning downward leaves the lowest last.
  always_comb begin
    sel_victim = fill_oldest;
    for (int unsigned i = NUM_WAYS; i > 0; i--) begin
      if (!valid_q[set_q][i-1]) begin
        sel_victim = WAY_W'(i - 1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    set_d        = set_q;
    ftag_d       = ftag_q;
    victim_d     = victim_q;
    old_tag_d    = old_tag_q;
    old_valid_d  = old_valid_q;
    flush_pend_d = flush_pend_q;
    flush_cnt_d  = flush_cnt_q;
    tags_d       = tags_q;
    valid_d      = valid_q;
    age_d        = age_q;
    touch_en     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        touch_en = 1'b1;
        if (flush_req || flush_pend_q) begin
          state_d      = ST_FLUSH;
          flush_cnt_d  = '0;
          flush_pend_d = 1'b0;
        end else if (fill_valid) begin
          state_d = ST_SEL;
          set_d   = fill_set;
          ftag_d  = fill_tag;
        end
      end
      ST_SEL: begin
        touch_en    = 1'b1;
        victim_d    = sel_victim;
        old_tag_d   = tags_q[set_q][sel_victim];
        old_valid_d = valid_q[set_q][sel_victim];
        if (flush_req) flush_pend_d = 1'b1;
        state_d = ST_WR;
      end
      ST_WR: begin
        // Fill's LRU update owns its set this cycle; same-set touches drop.
        touch_en                  = (touch_set != set_q);
        tags_d[set_q][victim_q]   = ftag_q;
        valid_d[set_q][victim_q]  = 1'b1;
        age_d[set_q]              = fill_age_new;
        if (flush_req) flush_pend_d = 1'b1;
        state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        valid_d[flush_cnt_q] = '0;
        age_d[flush_cnt_q]   = AGE_INIT;
        flush_cnt_d          = flush_cnt_q + 1'b1;
        if (flush_cnt_q == '1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (touch_valid && touch_en) begin
      age_d[touch_set] = touch_age_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      set_q        <= '0;
      ftag_q       <= '0;
      victim_q     <= '0;
      old_tag_q    <= '0;
      old_valid_q  <= 1'b0;
      flush_pend_q <= 1'b0;
      flush_cnt_q  <= '0;
      tags_q       <= '0;
      valid_q      <= '0;
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        age_q[s] <= AGE_INIT;
      end
    end else begin
      state_q      <= state_d;
      set_q        <= set_d;
      ftag_q       <= ftag_d;
      victim_q     <= victim_d;
      old_tag_q    <= old_tag_d;
      old_valid_q  <= old_valid_d;
      flush_pend_q <= flush_pend_d;
      flush_cnt_q  <= flush_cnt_d;
      tags_q       <= tags_d;
      valid_q      <= valid_d;
      age_q        <= age_d;
    end
  end

  assign fill_ready  = (state_q == ST_IDLE) && !flush_pend_q && !flush_req;
  assign fill_done   = (state_q == ST_WR);
  assign fill_way    = victim_q;
  assign evict_valid = fill_done && old_valid_q;
  assign evict_tag   = evict_valid ? old_tag_q : '0;
  assign flush_busy  = (state_q == ST_FLUSH) || flush_pend_q;

  assign rd_tag0  = tags_q[rd_set][0];
  assign rd_tag1  = tags_q[rd_set][1];
  assign rd_tag2  = tags_q[rd_set][2];
  assign rd_tag3  = tags_q[rd_set][3];
  assign rd_valid = valid_q[rd_set];

endmodule

// File: tb/tb_cache_tag_fill.sv
// Self-checking bench for cache_tag_fill: array-based reference model of
// tags/valid/ages, per-cycle output compare, plus literal pins.
module tb_cache_tag_fill;

  logic        clk;
  logic        rst;
  logic        fill_valid;
  logic        fill_ready;
  logic [2:0]  fill_set;
  logic [23:0] fill_tag;
  logic        fill_done;
  logic [1:0]  fill_way;
  logic        evict_valid;
  logic [23:0] evict_tag;
  logic        touch_valid;
  logic [2:0]  touch_set;
  logic [1:0]  touch_way;
  logic        flush_req;
  logic        flush_busy;
  logic [2:0]  rd_set;
  logic [23:0] rd_tag0, rd_tag1, rd_tag2, rd_tag3;
  logic [3:0]  rd_valid;

  cache_tag_fill #(.TAG_W(24), .SET_W(3)) dut (
    .clk(clk), .rst(rst),
    .fill_valid(fill_valid), .fill_ready(fill_ready),
    .fill_set(fill_set), .fill_tag(fill_tag),
    .fill_done(fill_done), .fill_way(fill_way),
    .evict_valid(evict_valid), .evict_tag(evict_tag),
    .touch_valid(touch_valid), .touch_set(touch_set), .touch_way(touch_way),
    .flush_req(flush_req), .flush_busy(flush_busy),
    .rd_set(rd_set),
    .rd_tag0(rd_tag0), .rd_tag1(rd_tag1), .rd_tag2(rd_tag2), .rd_tag3(rd_tag3),
    .rd_valid(rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [23:0] m_tag   [8][4];
  bit          m_valid [8][4];
  int          m_age   [8][4];

  bit          chk_on = 1'b0;
  bit          exp_done, exp_ready, exp_busy, exp_ev;
  int          exp_way;
  logic [23:0] exp_etag;
  int          cap_way;
  bit          cap_ev;
  logic [23:0] cap_etag;
  int          busy_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 4; w++) begin
        m_tag[s][w] = '0; m_valid[s][w] = 1'b0; m_age[s][w] = w;
      end
  endfunction

  function automatic int m_victim(input int s);
    for (int w = 0; w < 4; w++) if (!m_valid[s][w]) return w;
    for (int w = 0; w < 4; w++) if (m_age[s][w] == 3) return w;
    return -1;
  endfunction

  function automatic void m_use(input int s, input int w);
    int a = m_age[s][w];
    for (int i = 0; i < 4; i++) if (m_age[s][i] < a) m_age[s][i]++;
    m_age[s][w] = 0;
  endfunction

  always @(negedge clk) begin
    logic [3:0] mv;
    if (chk_on) begin
      for (int w = 0; w < 4; w++) mv[w] = m_valid[rd_set][w];
      chk("rd_valid", {28'd0, rd_valid}, {28'd0, mv});
      chk("rd_tag0", {8'd0, rd_tag0}, {8'd0, m_tag[rd_set][0]});
      chk("rd_tag1", {8'd0, rd_tag1}, {8'd0, m_tag[rd_set][1]});
      chk("rd_tag2", {8'd0, rd_tag2}, {8'd0, m_tag[rd_set][2]});
      chk("rd_tag3", {8'd0, rd_tag3}, {8'd0, m_tag[rd_set][3]});
      chk("fill_done", {31'd0, fill_done}, {31'd0, exp_done});
      chk("fill_ready", {31'd0, fill_ready}, {31'd0, exp_ready});
      chk("flush_busy", {31'd0, flush_busy}, {31'd0, exp_busy});
      if (exp_done) begin
        chk("fill_way", {30'd0, fill_way}, exp_way);
        chk("evict_valid", {31'd0, evict_valid}, {31'd0, exp_ev});
        chk("evict_tag", {8'd0, evict_tag}, {8'd0, exp_etag});
      end
      if (fill_done) begin
        cap_way = fill_way; cap_ev = evict_valid; cap_etag = evict_tag;
      end
      if (flush_busy) busy_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ages(input int s);
    for (int w = 0; w < 4; w++)
      chk("age_model", {30'd0, dut.age_q[s][w]}, m_age[s][w]);
  endtask

  task automatic run_flush();
    for (int k = 0; k < 8; k++) begin
      exp_busy = 1'b1; exp_ready = 1'b0;
      cyc();
      for (int w = 0; w < 4; w++) begin
        m_valid[k][w] = 1'b0; m_age[k][w] = w;
      end
    end
    exp_busy = 1'b0; exp_ready = 1'b1;
  endtask

  task automatic do_touch(input int s, input int w);
    touch_valid = 1'b1; touch_set = 3'(s); touch_way = 2'(w);
    cyc();
    m_use(s, w);
    touch_valid = 1'b0;
  endtask

  // tph: 0 none, 1 accept cycle, 2 select cycle, 3 write cycle
  task automatic do_fill(input int s, input logic [23:0] tag, input int tph,
                         input int ts, input int tw, input bit fl_sel);
    int v;
    fill_valid = 1'b1; fill_set = 3'(s); fill_tag = tag;
    exp_ready = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
    touch_valid = (tph == 1); touch_set = 3'(ts); touch_way = 2'(tw);
    cyc();
    if (tph == 1) m_use(ts, tw);
    fill_valid = 1'b0; exp_ready = 1'b0;
    touch_valid = (tph == 2);
    flush_req = fl_sel;
    cyc();
    v = m_victim(s);
    exp_way = v; exp_ev = m_valid[s][v];
    exp_etag = exp_ev ? m_tag[s][v] : 24'd0;
    if (tph == 2) m_use(ts, tw);
    flush_req = 1'b0;
    touch_valid = (tph == 3);
    exp_done = 1'b1; exp_busy = fl_sel;
    cyc();
    m_tag[s][v] = tag; m_valid[s][v] = 1'b1;
    m_use(s, v);
    if (tph == 3 && ts != s) m_use(ts, tw);
    touch_valid = 1'b0; exp_done = 1'b0;
    if (fl_sel) begin
      busy_cnt = 0;
      exp_busy = 1'b1; exp_ready = 1'b0;
      cyc();
      run_flush();
    end else begin
      exp_ready = 1'b1; exp_busy = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; fill_valid = 1'b0; fill_set = '0; fill_tag = '0;
    touch_valid = 1'b0; touch_set = '0; touch_way = '0;
    flush_req = 1'b0; rd_set = 3'd2;
    m_reset();
    exp_done = 1'b0; exp_ready = 1'b1; exp_busy = 1'b0;
    chk_on = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    chk("rst_fill_way", {30'd0, fill_way}, 32'd0);
    chk("rst_evict_tag", {8'd0, evict_tag}, 32'd0);
    chk("rst_age3", {30'd0, dut.age_q[2][3]}, 32'd3);
    rst = 1'b0;
    cyc();

    // Four fills into empty set 2 land in ways 0..3 without eviction
    for (int i = 0; i < 4; i++) begin
      do_fill(2, 24'hA00001 + 24'(i), 0, 0, 0, 1'b0);
      chk("t1_way", cap_way, i);
      chk("t1_noevict", {31'd0, cap_ev}, 32'd0);
    end
    @(negedge clk);
    chk("t1_rd_valid", {28'd0, rd_valid}, 32'hF);
    chk("t1_rd_tag3", {8'd0, rd_tag3}, 32'hA00004);

    // Touch ways 0,1,2 -> way 3 is oldest and gets evicted
    cyc();
    do_touch(2, 0); do_touch(2, 1); do_touch(2, 2);
    do_fill(2, 24'hB00000, 0, 0, 0, 1'b0);
    chk("t2_way", cap_way, 3);
    chk("t2_evict", {31'd0, cap_ev}, 32'd1);
    chk("t2_etag", {8'd0, cap_etag}, 32'hA00004);
    chk("t2_age0", {30'd0, dut.age_q[2][0]}, 32'd3);
    chk("t2_age3", {30'd0, dut.age_q[2][3]}, 32'd0);
    chk_ages(2);

    // Touch during the write cycle: same set dropped, other set applied
    rd_set = 3'd5;
    do_fill(5, 24'hC00001, 3, 5, 1, 1'b0);
    chk("t3_way", cap_way, 0);
    chk("t3_age0", {30'd0, dut.age_q[5][0]}, 32'd0);
    chk("t3_age1", {30'd0, dut.age_q[5][1]}, 32'd1);
    chk_ages(5);
    do_fill(5, 24'hC00002, 3, 6, 1, 1'b0);
    chk("t3b_way", cap_way, 1);
    chk("t3b_s6a1", {30'd0, dut.age_q[6][1]}, 32'd0);
    chk("t3b_s6a0", {30'd0, dut.age_q[6][0]}, 32'd1);
    chk_ages(5); chk_ages(6);

    // Flush requested during select: fill completes, then 8-set flush
    do_fill(3, 24'hD00001, 2, 2, 1, 1'b1);
    chk("t4_busy_len", busy_cnt, 9);
    for (int s = 0; s < 8; s++) begin
      rd_set = 3'(s);
      @(negedge clk);
      chk("t4_rd_valid", {28'd0, rd_valid}, 32'd0);
      chk_ages(s);
      cyc();
    end
    rd_set = 3'd2;
    do_fill(2, 24'hE00001, 0, 0, 0, 1'b0);
    chk("t4_way", cap_way, 0);
    chk("t4_noevict", {31'd0, cap_ev}, 32'd0);

    // Flush and fill in the same idle cycle: flush wins
    rd_set = 3'd4;
    fill_valid = 1'b1; fill_set = 3'd4; fill_tag = 24'hF00001; flush_req = 1'b1;
    exp_ready = 1'b0; exp_busy = 1'b0;
    cyc();
    flush_req = 1'b0;
    run_flush();
    do_fill(4, 24'hF00001, 0, 0, 0, 1'b0);
    chk("t5_way", cap_way, 0);

    // Reset one cycle after accepting a fill
    rd_set = 3'd2;
    fill_valid = 1'b1; fill_set = 3'd2; fill_tag = 24'h123456;
    exp_ready = 1'b1;
    cyc();
    fill_valid = 1'b0;
    rst = 1'b1;
    m_reset();
    cyc();
    rst = 1'b0;
    cyc(); cyc();
    for (int s = 0; s < 8; s++) begin
      rd_set = 3'(s);
      @(negedge clk);
      chk("t6_rd_valid", {28'd0, rd_valid}, 32'd0);
      for (int w = 0; w < 4; w++)
        chk("t6_age", {30'd0, dut.age_q[s][w]}, w);
      cyc();
    end
    chk("t6_ready", {31'd0, fill_ready}, 32'd1);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
